// File: rtl/conv_ps_param.sv
// conv_ps_param: width-selectable parallel<->serial converter, MSB first, valid/ready on the parallel side.
// Build macro CONV_PARITY_EN appends/checks one even-parity bit per word.
module conv_ps_param #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W+1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENB,
    input  logic              MODO,
    input  logic [1:0]        PCLK,
    input  logic [DATA_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sout,
    output logic              sout_valid,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              parity_err
);
`ifdef CONV_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SH_W = DATA_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, TX = 2'd1, RX = 2'd2} state_t;

    state_t            r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [CNT_W-1:0]  r_width, w_width_nx;
    logic [SH_W-1:0]   r_tx_sh, w_tx_sh_nx;
    logic [DATA_W-1:0] r_rx_sh, w_rx_sh_nx;
    logic [DATA_W-1:0] r_out, w_out_nx;
    logic              r_out_valid, w_out_valid_nx;
    logic              r_par_err, w_par_err_nx;

    logic [CNT_W-1:0]  w_width_cur, w_total_cur, w_rx_cnt, w_rx_width;
    logic [SH_W-1:0]   w_in_m, w_tx_word, w_tx_load, w_rx_sh;
    logic [DATA_W-1:0] w_rx_word;
    logic              w_rx_perr, w_rx_done, w_tx_last, w_do_load, w_do_rx;

    function automatic logic [SH_W-1:0] low_mask(input logic [CNT_W-1:0] n);
        low_mask = (SH_W'(1) << n) - SH_W'(1);
    endfunction

    assign w_width_cur = CNT_W'(DATA_W) >> PCLK;
    assign w_total_cur = w_width_cur + CNT_W'(PAR);
    assign w_in_m      = SH_W'(in) & low_mask(w_width_cur);
`ifdef CONV_PARITY_EN
    assign w_tx_word   = (w_in_m << 1) | SH_W'(^w_in_m);
`else
    assign w_tx_word   = w_in_m;
`endif
    // Left-align the word so bit W-1 sits at the MSB that drives sout.
    assign w_tx_load   = w_tx_word << (CNT_W'(SH_W) - w_total_cur);
    assign w_tx_last   = (r_state == TX) && (r_cnt == CNT_W'(1));

    assign w_rx_cnt    = (r_state == IDLE) ? w_total_cur : r_cnt;
    assign w_rx_width  = (r_state == IDLE) ? w_width_cur : r_width;
    assign w_rx_sh     = {r_rx_sh, sin};
    assign w_rx_done   = (w_rx_cnt == CNT_W'(1));
    assign w_rx_word   = DATA_W'((w_rx_sh >> PAR) & low_mask(w_rx_width));
`ifdef CONV_PARITY_EN
    assign w_rx_perr   = ^(w_rx_sh & low_mask(w_rx_width + CNT_W'(1)));
`else
    assign w_rx_perr   = 1'b0;
`endif

    // Next-state and datapath update; word loads and bit captures share one path per direction.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_width_nx     = r_width;
        w_tx_sh_nx     = r_tx_sh;
        w_rx_sh_nx     = r_rx_sh;
        w_out_nx       = r_out;
        w_out_valid_nx = 1'b0;
        w_par_err_nx   = 1'b0;
        w_do_load      = 1'b0;
        w_do_rx        = 1'b0;
        case (r_state)
            IDLE: begin
                if (MODO && in_valid) begin
                    w_do_load = 1'b1;
                end else if (!MODO && sin_valid) begin
                    w_do_rx = 1'b1;
                end else begin
                    w_cnt_nx = {CNT_W{1'b0}};
                end
            end
            TX: begin
                if (w_tx_last && MODO && in_valid) begin
                    w_do_load = 1'b1;
                end else if (w_tx_last) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = {CNT_W{1'b0}};
                end else begin
                    w_tx_sh_nx = {r_tx_sh[SH_W-2:0], 1'b0};
                    w_cnt_nx   = r_cnt - CNT_W'(1);
                end
            end
            RX: begin
                if (sin_valid) begin
                    w_do_rx = 1'b1;
                end else if (MODO && (r_cnt == r_width + CNT_W'(PAR))) begin
                    // No bit of the next word has arrived yet, so a mode change can take effect.
                    w_state_nx = IDLE;
                    w_cnt_nx   = {CNT_W{1'b0}};
                end else begin
                    w_state_nx = RX;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = {CNT_W{1'b0}};
            end
        endcase
        if (w_do_load) begin
            w_state_nx = TX;
            w_tx_sh_nx = w_tx_load;
            w_cnt_nx   = w_total_cur;
            w_width_nx = w_width_cur;
        end else if (w_do_rx) begin
            w_rx_sh_nx = w_rx_sh[DATA_W-1:0];
            if (w_rx_done) begin
                w_out_nx       = w_rx_word;
                w_out_valid_nx = 1'b1;
                w_par_err_nx   = w_rx_perr;
                w_width_nx     = w_width_cur;
                w_state_nx     = MODO ? IDLE : RX;
                w_cnt_nx       = MODO ? {CNT_W{1'b0}} : w_total_cur;
            end else begin
                w_state_nx = RX;
                w_cnt_nx   = w_rx_cnt - CNT_W'(1);
                w_width_nx = w_rx_width;
            end
        end else begin
            w_rx_sh_nx = r_rx_sh;
        end
    end

    // State registers; ENB low freezes everything without clearing it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_width     <= {CNT_W{1'b0}};
            r_tx_sh     <= {SH_W{1'b0}};
            r_rx_sh     <= {DATA_W{1'b0}};
            r_out       <= {DATA_W{1'b0}};
            r_out_valid <= 1'b0;
            r_par_err   <= 1'b0;
        end else if (ENB) begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_width     <= w_width_nx;
            r_tx_sh     <= w_tx_sh_nx;
            r_rx_sh     <= w_rx_sh_nx;
            r_out       <= w_out_nx;
            r_out_valid <= w_out_valid_nx;
            r_par_err   <= w_par_err_nx;
        end
    end

    assign in_ready   = ENB & ~RESET & (((r_state == IDLE) & MODO) | w_tx_last);
    assign sout       = r_tx_sh[SH_W-1];
    assign sout_valid = ENB & (r_state == TX);
    assign out        = r_out;
    assign out_valid  = ENB & r_out_valid;
    assign parity_err = ENB & r_par_err;

endmodule

// File: tb/tb_conv_ps_param.sv
// Directed self-checking bench for conv_ps_param (DATA_W=32); honours CONV_PARITY_EN when defined.
module tb_conv_ps_param;
`ifdef CONV_PARITY_EN
    localparam int          PAR      = 1;
    localparam logic [63:0] EXP_P32  = {31'd0, 32'h0F00FF55, 1'b0};
    localparam logic [63:0] EXP_B2B  = {38'd0, 16'h30EA, 1'b1, 8'hAE, 1'b1};
    localparam logic [63:0] EXP_FRZ  = {47'd0, 16'hC3A5, 1'b0};
    localparam logic [63:0] RX_AE    = {55'd0, 8'hAE, 1'b0};
    localparam logic        PERR_AE  = 1'b1;
    localparam logic [63:0] RX_9     = {59'd0, 4'h9, 1'b0};
`else
    localparam int          PAR      = 0;
    localparam logic [63:0] EXP_P32  = {32'd0, 32'h0F00FF55};
    localparam logic [63:0] EXP_B2B  = {40'd0, 16'h30EA, 8'hAE};
    localparam logic [63:0] EXP_FRZ  = {48'd0, 16'hC3A5};
    localparam logic [63:0] RX_AE    = {56'd0, 8'hAE};
    localparam logic        PERR_AE  = 1'b0;
    localparam logic [63:0] RX_9     = {60'd0, 4'h9};
`endif

    logic        clk = 1'b0;
    logic        rst, enb, modo, in_valid, sin, sin_valid;
    logic [1:0]  pclk;
    logic [31:0] din;
    logic        in_ready, sout, sout_valid, out_valid, parity_err;
    logic [31:0] dout;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] tx_bits;
    int          tx_nvalid, tx_ngap;

    always #5 clk = ~clk;

    conv_ps_param #(.DATA_W(32)) dut (
        .CLK(clk), .RESET(rst), .ENB(enb), .MODO(modo), .PCLK(pclk),
        .in(din), .in_valid(in_valid), .in_ready(in_ready),
        .sout(sout), .sout_valid(sout_valid),
        .sin(sin), .sin_valid(sin_valid),
        .out(dout), .out_valid(out_valid), .parity_err(parity_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer nw words (w0 then w1), collect the serial stream; ENB low for 5 cycles from frz_at (-1 = never).
    task automatic tx_stream(input logic [31:0] w0, input logic [1:0] p0,
                             input logic [31:0] w1, input logic [1:0] p1,
                             input int nw, input int frz_at, input int ncyc);
        int  idx = 0;
        int  low = 0;
        bit  seen = 1'b0;
        bit  acc;
        tx_bits = 64'd0; tx_nvalid = 0; tx_ngap = 0;
        @(posedge clk); #1;
        modo = 1'b1; pclk = p0; din = w0; in_valid = 1'b1; enb = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (sout_valid) begin
                tx_bits = {tx_bits[62:0], sout};
                tx_nvalid++;
                if (seen) tx_ngap += low;
                low  = 0;
                seen = 1'b1;
            end else if (seen) begin
                low++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                if (idx + 1 < nw) begin
                    idx++;
                    din  = w1;
                    pclk = p1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            enb = !(frz_at >= 0 && i + 1 >= frz_at && i + 1 < frz_at + 5);
        end
        enb = 1'b1;
    endtask

    // Feed n bits MSB first with a 3-cycle sin_valid gap before bit index gap_at; optionally raise MODO on the last bit.
    task automatic rx_word(input string tag, input logic [1:0] p, input logic [63:0] bits, input int n,
                           input int gap_at, input logic leave,
                           input logic [31:0] exp_out, input logic exp_perr);
        int early = 0;
        @(posedge clk); #1;
        modo = 1'b0; pclk = p; enb = 1'b1;
        for (int j = 0; j < n; j++) begin
            if (j == gap_at) begin
                sin_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (out_valid) early++;
                    @(posedge clk); #1;
                end
            end
            sin       = bits[n-1-j];
            sin_valid = 1'b1;
            if (j == n - 1 && leave) modo = 1'b1;
            @(negedge clk);
            if (out_valid) early++;
            @(posedge clk); #1;
        end
        sin_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_early"}, 64'(early), 64'd0);
        check_eq({tag, "_ovalid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_out"}, 64'(dout), 64'(exp_out));
        check_eq({tag, "_perr"}, 64'(parity_err), 64'(exp_perr));
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_hold"}, 64'(dout), 64'(exp_out));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enb = 1'b1; modo = 1'b1; pclk = 2'b00; din = 32'd0;
        in_valid = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_sout", 64'(sout), 64'd0);
        check_eq("rst_sout_valid", 64'(sout_valid), 64'd0);
        check_eq("rst_out", 64'(dout), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_parity_err", 64'(parity_err), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check_eq("rel_in_ready", 64'(in_ready), 64'd1);

        // Reset asserted while a 32-bit word is on the wire.
        @(posedge clk); #1; din = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midtx_sout_valid", 64'(sout_valid), 64'd1);
        check_eq("midtx_sout", 64'(sout), 64'd1);
        #2; rst = 1'b1; #1;
        check_eq("async_sout_valid", 64'(sout_valid), 64'd0);
        check_eq("async_sout", 64'(sout), 64'd0);
        check_eq("async_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("post_rst_sout_valid", 64'(sout_valid), 64'd0);
        repeat (2) @(negedge clk);
        check_eq("partial_dropped", 64'(sout_valid), 64'd0);

        tx_stream(32'h0F00FF55, 2'b00, 32'd0, 2'b00, 1, -1, 40);
        check_eq("p2s32_bits", tx_bits, EXP_P32);
        check_eq("p2s32_nvalid", 64'(tx_nvalid), 64'(32 + PAR));

        tx_stream(32'h000030EA, 2'b01, 32'h000000AE, 2'b10, 2, -1, 36);
        check_eq("b2b_bits", tx_bits, EXP_B2B);
        check_eq("b2b_nvalid", 64'(tx_nvalid), 64'(24 + 2 * PAR));
        check_eq("b2b_gap", 64'(tx_ngap), 64'd0);

        tx_stream(32'h0000C3A5, 2'b01, 32'd0, 2'b00, 1, 6, 30);
        check_eq("freeze_bits", tx_bits, EXP_FRZ);
        check_eq("freeze_nvalid", 64'(tx_nvalid), 64'(16 + PAR));

        rx_word("rx_ae", 2'b10, RX_AE, 8 + PAR, 4, 1'b1, 32'h000000AE, PERR_AE);
        rx_word("rx_9", 2'b11, RX_9, 4 + PAR, -1, 1'b0, 32'h00000009, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
